// File: rtl/mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl
//
// Issue and writeback controller for the multi-cycle multiplier in a 3-stage
// pipeline (IF/ID -> ID/EX -> EX/WB). It launches the multiplier and remembers
// the destination register of the multiply in flight. It raises stall for
// structural, RAW and WAW hazards on that register. It also owns the single
// register-file write port, so that the pipeline writer and the multiplier
// writer never use the port in the same cycle.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   id_valid          instruction present in ID
//   id_rs, id_rt      source registers of the ID instruction
//   id_rd             destination register of the ID instruction
//   id_reg_write      ID instruction writes the register file via the pipeline
//   id_is_mul         ID instruction is a multiply (always writes id_rd)
//   ex_wb_reg_write   EX/WB stage write enable
//   ex_wb_rd          EX/WB stage destination
//   stall             hold PC and IF/ID, bubble into ID/EX (combinational)
//   mul_start         one-cycle launch pulse to the multiplier (combinational)
//   mul_busy          multiplier occupied (state != IDLE)
//   wb_sel            0 = EX/WB result to regfile, 1 = multiplier result
//   wb_en, wb_rd      register-file write enable and address
//   wb_collision      error pulse: EX/WB tried to write in the multiplier slot
// ---------------------------------------------------------------------------
module mul_issue_ctrl #(
  parameter int REG_AW  = 3,
  parameter int MUL_LAT = 4   // accept at t, write at t+MUL_LAT; must be >= 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_mul,
  input  logic              ex_wb_reg_write,
  input  logic [REG_AW-1:0] ex_wb_rd,
  output logic              stall,
  output logic              mul_start,
  output logic              mul_busy,
  output logic              wb_sel,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_collision
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [REG_AW-1:0] mul_rd_reg, mul_rd_next;

  logic pend;
  logic haz_struct, haz_raw, haz_waw, haz_port;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      mul_rd_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      mul_rd_reg <= mul_rd_next;
    end
  end

  // Hazard detection, next state and outputs
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    mul_rd_next  = mul_rd_reg;
    stall        = 1'b0;
    mul_start    = 1'b0;
    wb_sel       = 1'b0;
    wb_en        = ex_wb_reg_write;
    wb_rd        = ex_wb_rd;
    wb_collision = 1'b0;

    // mul_rd stays pending from the cycle after accept through the WB cycle
    pend       = (state_reg != IDLE);
    haz_struct = id_is_mul & pend;
    haz_raw    = pend & ((id_rs == mul_rd_reg) | (id_rt == mul_rd_reg));
    haz_waw    = pend & (id_reg_write | id_is_mul) & (id_rd == mul_rd_reg);
    // A pipeline writer in ID now reaches the write port two cycles later.
    // With cnt==2 in BUSY, that cycle is the multiplier's WB slot.
    haz_port   = (state_reg == BUSY) & (cnt_reg == CNT_TWO) &
                 id_reg_write & ~id_is_mul;

    stall     = id_valid & (haz_struct | haz_raw | haz_waw | haz_port);
    mul_start = id_valid & id_is_mul & ~stall;

    unique case (state_reg)
      IDLE: begin
        // Structural stall guarantees mul_start only fires here
        if (mul_start) begin
          state_next  = BUSY;
          cnt_next    = CNT_LOAD;
          mul_rd_next = id_rd;
        end
      end
      BUSY: begin
        if (cnt_reg == CNT_ONE) begin
          state_next = WB;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      WB: begin
        state_next   = IDLE;
        // Multiplier owns the port this cycle; a pipeline write is an error
        wb_sel       = 1'b1;
        wb_en        = 1'b1;
        wb_rd        = mul_rd_reg;
        wb_collision = ex_wb_reg_write;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mul_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

  localparam int REG_AW  = 3;
  localparam int MUL_LAT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_reg_write, id_is_mul, ex_wb_reg_write;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd, ex_wb_rd;
  logic              stall, mul_start, mul_busy, wb_sel, wb_en, wb_collision;
  logic [REG_AW-1:0] wb_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_mul(id_is_mul),
    .ex_wb_reg_write(ex_wb_reg_write), .ex_wb_rd(ex_wb_rd),
    .stall(stall), .mul_start(mul_start), .mul_busy(mul_busy),
    .wb_sel(wb_sel), .wb_en(wb_en), .wb_rd(wb_rd), .wb_collision(wb_collision)
  );

  // Reference model: "cycles left until the multiplier writes" plus a
  // two-deep pipeline of issued writers feeding the EX/WB stage.
  bit              m_active;
  int              m_left;
  logic [REG_AW-1:0] m_rd;
  bit              p1_we, p2_we;
  logic [REG_AW-1:0] p1_rd, p2_rd;
  bit              force_en, force_we;
  logic [REG_AW-1:0] force_rd;

  task automatic model_clear();
    m_active = 0; m_left = 0; m_rd = '0;
    p1_we = 0; p2_we = 0; p1_rd = '0; p2_rd = '0;
  endtask

  function automatic bit m_stall();
    bit pend, s, r, w, c;
    pend = m_active;
    s = id_is_mul && pend;
    r = pend && (id_rs == m_rd || id_rt == m_rd);
    w = pend && (id_reg_write || id_is_mul) && id_rd == m_rd;
    // pipeline writer issued now writes in 2 cycles: clash with mul write?
    c = m_active && (m_left == 2) && id_reg_write && !id_is_mul;
    return id_valid && (s || r || w || c);
  endfunction

  task automatic chk1(string tag, logic obs, logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_rd(string tag, logic [REG_AW-1:0] obs, logic [REG_AW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    bit es, wbc;
    es  = m_stall();
    wbc = m_active && (m_left == 0);
    chk1({tag, " stall"}, stall, es);
    chk1({tag, " mul_start"}, mul_start, id_valid && id_is_mul && !es);
    chk1({tag, " mul_busy"}, mul_busy, m_active);
    chk1({tag, " wb_sel"}, wb_sel, wbc);
    chk1({tag, " wb_en"}, wb_en, wbc ? 1'b1 : ex_wb_reg_write);
    chk_rd({tag, " wb_rd"}, wb_rd, wbc ? m_rd : ex_wb_rd);
    chk1({tag, " wb_collision"}, wb_collision, wbc && ex_wb_reg_write);
  endtask

  task automatic drive(bit v, logic [REG_AW-1:0] rs, logic [REG_AW-1:0] rt,
                       logic [REG_AW-1:0] rd, bit rw, bit mul);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_reg_write = rw; id_is_mul = mul;
    ex_wb_reg_write = force_en ? force_we : p2_we;
    ex_wb_rd        = force_en ? force_rd : p2_rd;
    #3;
  endtask

  task automatic tick();
    bit es, acc, iss;
    es  = m_stall();
    acc = id_valid && id_is_mul && !es;
    iss = id_valid && id_reg_write && !id_is_mul && !es;
    @(posedge clk);
    p2_we = p1_we; p2_rd = p1_rd;
    p1_we = iss;   p1_rd = id_rd;
    if (m_active) begin
      if (m_left == 0) m_active = 0;
      else m_left--;
    end
    if (acc) begin
      m_active = 1; m_left = MUL_LAT - 1; m_rd = id_rd;
    end
    #1;
  endtask

  task automatic idle_step(string tag);
    drive(0, 0, 0, 0, 0, 0);
    check_all(tag);
    tick();
  endtask

  initial begin
    force_en = 0; force_we = 0; force_rd = '0;
    model_clear();
    rst = 1'b1;
    // Reset state; combinational outputs follow inputs as in IDLE
    @(posedge clk); #1;
    drive(1, 3, 4, 5, 0, 1);
    chk1("reset mul_busy", mul_busy, 1'b0);
    chk1("reset wb_sel", wb_sel, 1'b0);
    chk1("reset wb_collision", wb_collision, 1'b0);
    chk1("reset stall", stall, 1'b0);
    chk1("reset mul_start", mul_start, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: basic multiply, rd=3
    drive(1, 0, 1, 3, 0, 1);
    chk1("t1 start c0", mul_start, 1'b1);
    check_all("t1 c0"); tick();
    for (int c = 1; c <= 5; c++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk1("t1 start", mul_start, 1'b0);
      chk1("t1 busy", mul_busy, c <= 4);
      chk1("t1 wb_sel", wb_sel, c == 4);
      if (c == 4) chk_rd("t1 wb_rd", wb_rd, 3'd3);
      check_all("t1"); tick();
    end

    // 2: RAW on r3
    drive(1, 0, 1, 3, 0, 1); check_all("t2 c0"); tick();
    for (int c = 1; c <= 5; c++) begin
      drive(1, 3, 1, 6, 1, 0);
      chk1("t2 raw stall", stall, c <= 4);
      check_all("t2"); tick();
    end
    repeat (3) idle_step("t2 drain");

    // 3: write-port hazard, add rd=5 in ID at cnt==2
    drive(1, 0, 1, 3, 0, 1); check_all("t3 c0"); tick();
    idle_step("t3 c1");
    for (int c = 2; c <= 3; c++) begin
      drive(1, 1, 2, 5, 1, 0);
      chk1("t3 port stall", stall, c == 2);
      check_all("t3"); tick();
    end
    for (int c = 4; c <= 5; c++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk1("t3 collision", wb_collision, 1'b0);
      if (c == 5) begin
        chk1("t3 add wb_en", wb_en, 1'b1);
        chk1("t3 add wb_sel", wb_sel, 1'b0);
        chk_rd("t3 add wb_rd", wb_rd, 3'd5);
      end
      check_all("t3"); tick();
    end

    // 4: back-to-back multiplies
    drive(1, 0, 1, 3, 0, 1); check_all("t4 c0"); tick();
    for (int c = 1; c <= 5; c++) begin
      drive(1, 0, 0, 4, 0, 1);
      chk1("t4 stall", stall, c <= 4);
      chk1("t4 start", mul_start, c == 5);
      check_all("t4"); tick();
    end
    for (int c = 6; c <= 9; c++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk1("t4 wb_sel", wb_sel, c == 9);
      if (c == 9) chk_rd("t4 wb_rd", wb_rd, 3'd4);
      check_all("t4"); tick();
    end

    // 5: store does not stall; add rd=3 stalls on WAW until cycle 5
    drive(1, 0, 1, 3, 0, 1); check_all("t5 c0"); tick();
    idle_step("t5 c1");
    drive(1, 1, 2, 3, 0, 0);
    chk1("t5 store stall", stall, 1'b0);
    check_all("t5 store"); tick();
    repeat (3) idle_step("t5 drain");
    drive(1, 0, 1, 3, 0, 1); check_all("t5b c0"); tick();
    idle_step("t5b c1");
    for (int c = 2; c <= 5; c++) begin
      drive(1, 1, 2, 3, 1, 0);
      chk1("t5 waw stall", stall, c <= 4);
      check_all("t5b"); tick();
    end
    repeat (3) idle_step("t5b drain");

    // 6: reset in the middle of a multiply
    drive(1, 0, 1, 3, 0, 1); check_all("t6 c0"); tick();
    idle_step("t6 c1");
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1; #1;
    chk1("t6 busy async", mul_busy, 1'b0);
    chk1("t6 wb_sel async", wb_sel, 1'b0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 0, 1, 2, 0, 1);
    chk1("t6 restart", mul_start, 1'b1);
    chk1("t6 no wb", wb_sel, 1'b0);
    check_all("t6 r0"); tick();
    repeat (MUL_LAT + 1) idle_step("t6 drain");

    // Forced collision: EX/WB writes in the multiplier slot
    drive(1, 0, 1, 6, 0, 1); check_all("fc c0"); tick();
    repeat (MUL_LAT - 1) idle_step("fc busy");
    force_en = 1; force_we = 1; force_rd = 3'd2;
    drive(0, 0, 0, 0, 0, 0);
    chk1("fc collision", wb_collision, 1'b1);
    chk_rd("fc wb_rd", wb_rd, 3'd6);
    check_all("fc wb"); tick();
    force_en = 0;
    idle_step("fc after");

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      force_en = ($urandom_range(0, 99) < 5);
      force_we = 1'(($urandom & 1));
      force_rd = REG_AW'($urandom);
      drive(($urandom_range(0, 9) < 8), REG_AW'($urandom), REG_AW'($urandom),
            REG_AW'($urandom), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; #1;
        chk1("rnd rst busy", mul_busy, 1'b0);
        chk1("rnd rst wb_sel", wb_sel, 1'b0);
        chk1("rnd rst collision", wb_collision, 1'b0);
        rst = 1'b0;
        model_clear();
      end
      check_all("rnd"); tick();
    end
    force_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
